// File: rtl/vend_dispense_if.sv
// Vend output-stage bus: vend request/change in, mechanism ack in, actuator drives and status out.
// Optional stats counters appear when VEND_DISPENSE_STATS_EN is defined.
interface vend_dispense_if;
   logic        soda_i;
   logic [2:0]  change_i;
   logic        eject_ack_i;
   logic        busy_o;
   logic        soda_eject_o;
   logic        coin_eject_o;
   logic [2:0]  pending_o;
   logic        fault_o;
`ifdef VEND_DISPENSE_STATS_EN
   logic [15:0] vend_count_o;
   logic [15:0] coin_count_o;
`endif

   modport master (
      output soda_i, change_i, eject_ack_i,
      input  busy_o, soda_eject_o, coin_eject_o, pending_o, fault_o
`ifdef VEND_DISPENSE_STATS_EN
      , input vend_count_o, coin_count_o
`endif
   );

   modport slave (
      input  soda_i, change_i, eject_ack_i,
      output busy_o, soda_eject_o, coin_eject_o, pending_o, fault_o
`ifdef VEND_DISPENSE_STATS_EN
      , output vend_count_o, coin_count_o
`endif
   );
endinterface

// File: rtl/vend_dispense.sv
// Vend output sequencer: one timed soda pulse, then one pulse per nickel, each awaiting an ack.
// Define VEND_DISPENSE_STATS_EN to add saturating vend/coin ack counters.
module vend_dispense #(
   parameter int unsigned PULSE_W     = 4,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input logic            clk_i,
   input logic            reset_i,
   vend_dispense_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, SODA_PULSE, SODA_WAIT, COIN_PULSE, COIN_WAIT, FAULT
   } state_t;

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
   localparam logic [7:0] TMO_LAST   = 8'(ACK_TIMEOUT - 1);

   state_t      state_reg;
   logic        soda_q;
   logic [2:0]  pending_reg;
   logic [3:0]  pulse_cnt_reg;
   logic [7:0]  tmo_cnt_reg;
   logic        trigger;

   assign trigger = bus.soda_i & ~soda_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg     <= IDLE;
         soda_q        <= 1'b0;
         pending_reg   <= 3'd0;
         pulse_cnt_reg <= 4'd0;
         tmo_cnt_reg   <= 8'd0;
      end else begin
         soda_q <= bus.soda_i;
         case (state_reg)
            IDLE: begin
               if (trigger) begin
                  pending_reg   <= bus.change_i;
                  pulse_cnt_reg <= 4'd0;
                  state_reg     <= SODA_PULSE;
               end
            end
            SODA_PULSE, COIN_PULSE: begin
               if (pulse_cnt_reg == PULSE_LAST) begin
                  tmo_cnt_reg <= 8'd0;
                  state_reg   <= (state_reg == SODA_PULSE) ? SODA_WAIT : COIN_WAIT;
               end else begin
                  pulse_cnt_reg <= pulse_cnt_reg + 4'd1;
               end
            end
            SODA_WAIT, COIN_WAIT: begin
               // An ack on the edge the timeout would expire still counts.
               if (bus.eject_ack_i) begin
                  pulse_cnt_reg <= 4'd0;
                  if (state_reg == SODA_WAIT) begin
                     state_reg <= (pending_reg != 3'd0) ? COIN_PULSE : IDLE;
                  end else begin
                     pending_reg <= pending_reg - 3'd1;
                     state_reg   <= (pending_reg != 3'd1) ? COIN_PULSE : IDLE;
                  end
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                  if (tmo_cnt_reg == TMO_LAST)
                     state_reg <= FAULT;
               end
            end
            FAULT: state_reg <= FAULT;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy_o       = (state_reg != IDLE);
   assign bus.soda_eject_o = (state_reg == SODA_PULSE);
   assign bus.coin_eject_o = (state_reg == COIN_PULSE);
   assign bus.fault_o      = (state_reg == FAULT);
   assign bus.pending_o    = pending_reg;

`ifdef VEND_DISPENSE_STATS_EN
   logic [15:0] vend_count_reg;
   logic [15:0] coin_count_reg;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vend_count_reg <= 16'd0;
         coin_count_reg <= 16'd0;
      end else if (bus.eject_ack_i) begin
         if (state_reg == SODA_WAIT && vend_count_reg != 16'hFFFF)
            vend_count_reg <= vend_count_reg + 16'd1;
         if (state_reg == COIN_WAIT && coin_count_reg != 16'hFFFF)
            coin_count_reg <= coin_count_reg + 16'd1;
      end
   end

   assign bus.vend_count_o = vend_count_reg;
   assign bus.coin_count_o = coin_count_reg;
`endif
endmodule
